// File: rtl/memory_stage_lsu.sv
// memory_stage_lsu
//   Memory stage of an in-order pipeline with a req/gnt/rvalid data bus.
//   Holds the E->M and M->W pipeline registers and sequences each aligned
//   load/store through the bus, stalling the front of the pipe meanwhile.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   *E inputs                  execute-stage results captured into M
//   dmem_req/we/addr/wdata/be  bus request, held stable until dmem_gnt
//   dmem_gnt/rvalid/rdata      bus grant and load response
//   StallM                     freezes F/D/E and the M register
//   ALUResultM, RdM, RegWriteM forwarding taps from M
//   misaligned_err             one-cycle flag for a misaligned half/word op
//   *W outputs                 M->W register contents
module memory_stage_lsu #(
    parameter int word_width = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWriteE,
    input  logic [1:0]            ResultSrcE,
    input  logic [1:0]            MemWriteE,
    input  logic [2:0]            LoadSizeE,
    input  logic [4:0]            RdE,
    input  logic [word_width-1:0] ALUResultE,
    input  logic [word_width-1:0] WriteDataE,
    input  logic [word_width-1:0] PCPlus4E,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [word_width-1:0] dmem_addr,
    output logic [word_width-1:0] dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [word_width-1:0] dmem_rdata,
    output logic                  StallM,
    output logic [word_width-1:0] ALUResultM,
    output logic [4:0]            RdM,
    output logic                  RegWriteM,
    output logic                  misaligned_err,
    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW,
    output logic [4:0]            RdW,
    output logic [word_width-1:0] ALUResultW,
    output logic [word_width-1:0] ReadDataW,
    output logic [word_width-1:0] PCPlus4W
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

    state_t state_q, state_d;

    logic                  regwrite_m_q;
    logic [1:0]            resultsrc_m_q;
    logic [1:0]            memwrite_m_q;
    logic [2:0]            loadsize_m_q;
    logic [4:0]            rd_m_q;
    logic [word_width-1:0] aluresult_m_q;
    logic [word_width-1:0] writedata_m_q;
    logic [word_width-1:0] pcplus4_m_q;

    logic                  regwrite_w_q;
    logic [1:0]            resultsrc_w_q;
    logic [4:0]            rd_w_q;
    logic [word_width-1:0] aluresult_w_q;
    logic [word_width-1:0] readdata_w_q;
    logic [word_width-1:0] pcplus4_w_q;

    logic       is_store, is_load, is_mem, misaligned, aligned_mem, complete;
    logic [1:0] size_m;   // 00 byte, 01 half, 10 word
    logic [1:0] byte_off;

    // Picks the addressed lane out of the bus word and extends it.
    function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  funct3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (funct3[1:0])
            2'b00:   r = funct3[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   r = funct3[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // Replicates store data across every lane it could land in.
    function automatic logic [31:0] store_replicate(input logic [31:0] wd,
                                                    input logic [1:0]  size);
        logic [31:0] r;
        case (size)
            2'b00:   r = {4{wd[7:0]}};
            2'b01:   r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    // Decode of the op currently held in M; a store wins if both are flagged.
    always_comb begin
        is_store = (memwrite_m_q != 2'b00);
        is_load  = !is_store && (resultsrc_m_q == 2'b01);
        is_mem   = is_store || is_load;
        size_m   = is_store ? (memwrite_m_q - 2'd1) : loadsize_m_q[1:0];
        byte_off = aluresult_m_q[1:0];
        case (size_m)
            2'b01:   misaligned = is_mem && byte_off[0];
            2'b10:   misaligned = is_mem && (byte_off != 2'b00);
            default: misaligned = 1'b0;
        endcase
        aligned_mem = is_mem && !misaligned;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state. rvalid is only looked at once the grant has been seen.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, REQ: begin
                if (aligned_mem && dmem_gnt) state_d = is_load ? RESP : IDLE;
                else if (aligned_mem)        state_d = REQ;
                else                         state_d = IDLE;
            end
            RESP:    if (dmem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs. The request goes out in the very cycle the op lands in M.
    always_comb begin
        dmem_req = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE, REQ: begin
                dmem_req = aligned_mem;
                complete = aligned_mem && is_store && dmem_gnt;
            end
            RESP:    complete = aligned_mem && dmem_rvalid;
            default: ;
        endcase
        StallM = aligned_mem && !complete;
    end

    always_comb begin
        dmem_we    = dmem_req && is_store;
        dmem_addr  = {aluresult_m_q[31:2], 2'b00};
        dmem_wdata = store_replicate(writedata_m_q, size_m);
        dmem_be    = 4'b0000;
        if (dmem_req) begin
            case (size_m)
                2'b00:   dmem_be = 4'b0001 << byte_off;
                2'b01:   dmem_be = 4'b0011 << byte_off;
                default: dmem_be = 4'b1111;
            endcase
        end
    end

    // E -> M register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_m_q  <= 1'b0;
            resultsrc_m_q <= 2'b00;
            memwrite_m_q  <= 2'b00;
            loadsize_m_q  <= 3'b000;
            rd_m_q        <= 5'd0;
            aluresult_m_q <= '0;
            writedata_m_q <= '0;
            pcplus4_m_q   <= '0;
        end else if (!StallM) begin
            regwrite_m_q  <= RegWriteE;
            resultsrc_m_q <= ResultSrcE;
            memwrite_m_q  <= MemWriteE;
            loadsize_m_q  <= LoadSizeE;
            rd_m_q        <= RdE;
            aluresult_m_q <= ALUResultE;
            writedata_m_q <= WriteDataE;
            pcplus4_m_q   <= PCPlus4E;
        end
    end

    // M -> W register; a stalled edge injects a bubble, a misaligned op retires without writing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_w_q  <= 1'b0;
            resultsrc_w_q <= 2'b00;
            rd_w_q        <= 5'd0;
            aluresult_w_q <= '0;
            readdata_w_q  <= '0;
            pcplus4_w_q   <= '0;
        end else if (StallM) begin
            regwrite_w_q  <= 1'b0;
            resultsrc_w_q <= 2'b00;
            rd_w_q        <= 5'd0;
        end else begin
            regwrite_w_q  <= regwrite_m_q && !misaligned;
            resultsrc_w_q <= resultsrc_m_q;
            rd_w_q        <= rd_m_q;
            aluresult_w_q <= aluresult_m_q;
            readdata_w_q  <= load_extend(dmem_rdata, byte_off, loadsize_m_q);
            pcplus4_w_q   <= pcplus4_m_q;
        end
    end

    assign ALUResultM     = aluresult_m_q;
    assign RdM            = rd_m_q;
    assign RegWriteM      = regwrite_m_q;
    assign misaligned_err = misaligned;
    assign RegWriteW      = regwrite_w_q;
    assign ResultSrcW     = resultsrc_w_q;
    assign RdW            = rd_w_q;
    assign ALUResultW     = aluresult_w_q;
    assign ReadDataW      = readdata_w_q;
    assign PCPlus4W       = pcplus4_w_q;

endmodule

// File: tb/tb_memory_stage_lsu.sv
module tb_memory_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteE;
    logic [1:0]  ResultSrcE;
    logic [1:0]  MemWriteE;
    logic [2:0]  LoadSizeE;
    logic [4:0]  RdE;
    logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        StallM;
    logic [31:0] ALUResultM;
    logic [4:0]  RdM;
    logic        RegWriteM, misaligned_err;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;

    int checks = 0;
    int errors = 0;

    memory_stage_lsu #(.word_width(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .LoadSizeE(LoadSizeE), .RdE(RdE), .ALUResultE(ALUResultE),
        .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .StallM(StallM), .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
        .misaligned_err(misaligned_err),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    typedef struct {
        logic        ld;
        logic [1:0]  mw;
        logic [2:0]  ls;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [10];
    logic [2:0] lsz_tab [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_e(input logic rw, input logic [1:0] rs, input logic [1:0] mw,
                         input logic [2:0] ls, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc4);
        RegWriteE  = rw;
        ResultSrcE = rs;
        MemWriteE  = mw;
        LoadSizeE  = ls;
        RdE        = rd;
        ALUResultE = alu;
        WriteDataE = wd;
        PCPlus4E   = pc4;
    endtask

    task automatic nop_e();
        set_e(1'b0, 2'b00, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    // Put one op into M: drive it on E for one edge, then return E to a nop.
    task automatic issue(input logic rw, input logic [1:0] rs, input logic [1:0] mw,
                         input logic [2:0] ls, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc4);
        set_e(rw, rs, mw, ls, rd, alu, wd, pc4);
        tick();
        nop_e();
    endtask

    // Randomised ops checked against a transaction-level model of the stage.
    task automatic run_random(input int count);
        int          kind, nbytes, off, gd, rdl, S;
        logic        rw, mis, is_load, is_store;
        logic [1:0]  rs, mw;
        logic [2:0]  ls;
        logic [4:0]  rd;
        logic [31:0] alu, wd, pc4, rdata, exp_rd, exp_wd, sh;
        logic [3:0]  exp_be;
        for (int n = 0; n < count; n++) begin
            kind = $urandom_range(0, 2);
            rd   = 5'($urandom);
            alu  = $urandom;
            wd   = $urandom;
            pc4  = $urandom;
            rdata = $urandom;
            gd   = $urandom_range(0, 3);
            rdl  = $urandom_range(1, 3);
            ls   = 3'b000;
            mw   = 2'b00;
            nbytes = 1;
            if (kind == 0) begin
                rs = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
                rw = 1'($urandom);
                ls = 3'($urandom);
            end else if (kind == 1) begin
                rs = 2'b01;
                rw = 1'b1;
                ls = lsz_tab[$urandom_range(0, 4)];
                nbytes = 1 << ls[1:0];
            end else begin
                rs = 2'b00;
                rw = 1'b0;
                mw = 2'($urandom_range(1, 3));
                nbytes = 1 << (mw - 1);
            end
            if ($urandom_range(0, 3) != 0) alu = alu & ~(32'(nbytes) - 32'd1);
            off      = int'(alu % 4);
            is_load  = (kind == 1);
            is_store = (kind == 2);
            mis      = (kind != 0) && ((alu % 32'(nbytes)) != 0);
            exp_be   = 4'(((1 << nbytes) - 1) << off);
            if (nbytes == 1)      exp_wd = (wd & 32'hFF) * 32'h01010101;
            else if (nbytes == 2) exp_wd = (wd & 32'hFFFF) * 32'h00010001;
            else                  exp_wd = wd;
            sh = rdata >> (8 * off);
            if (nbytes == 1) begin
                exp_rd = sh & 32'hFF;
                if (!ls[2] && exp_rd >= 128) exp_rd = exp_rd - 256;
            end else if (nbytes == 2) begin
                exp_rd = sh & 32'hFFFF;
                if (!ls[2] && exp_rd >= 32768) exp_rd = exp_rd - 65536;
            end else begin
                exp_rd = rdata;
            end

            issue(rw, rs, mw, ls, rd, alu, wd, pc4);
            if (kind != 0 && !mis) begin
                S = is_store ? gd : gd + rdl;
                for (int c = 0; c <= S; c++) begin
                    dmem_gnt    = (c == gd);
                    dmem_rvalid = (is_load && c > gd) ? (c == gd + rdl) : 1'($urandom);
                    dmem_rdata  = (is_load && c == gd + rdl) ? rdata : $urandom;
                    #4;
                    chk("rnd_stall", 32'(StallM), 32'(c < S));
                    chk("rnd_req", 32'(dmem_req), 32'(c <= gd));
                    if (c <= gd) begin
                        chk("rnd_addr", dmem_addr, alu - (alu % 4));
                        chk("rnd_we", 32'(dmem_we), 32'(is_store));
                        chk("rnd_be", 32'(dmem_be), 32'(exp_be));
                        if (is_store) chk("rnd_wdata", dmem_wdata, exp_wd);
                    end
                    tick();
                    if (c < S) chk("rnd_bubble", 32'(RegWriteW), 32'd0);
                end
                chk("rnd_rw_w", 32'(RegWriteW), 32'(rw));
                chk("rnd_rd_w", 32'(RdW), 32'(rd));
                chk("rnd_alu_w", ALUResultW, alu);
                chk("rnd_pc4_w", PCPlus4W, pc4);
                if (is_load) chk("rnd_rdata_w", ReadDataW, exp_rd);
            end else begin
                dmem_gnt    = 1'($urandom);
                dmem_rvalid = 1'($urandom);
                dmem_rdata  = $urandom;
                #4;
                chk("rnd_nm_stall", 32'(StallM), 32'd0);
                chk("rnd_nm_req", 32'(dmem_req), 32'd0);
                chk("rnd_mis", 32'(misaligned_err), 32'(mis));
                tick();
                chk("rnd_nm_rw_w", 32'(RegWriteW), 32'(rw && !mis));
                chk("rnd_nm_rd_w", 32'(RdW), 32'(rd));
                chk("rnd_nm_alu_w", ALUResultW, alu);
            end
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
        end
    endtask

    initial begin
        int stalls;
        vecs[0] = '{1'b0, 2'b01, 3'b000, 32'h01, 32'h000000A5, 32'h0, 4'b0010, 32'hA5A5A5A5, 32'h0};
        vecs[1] = '{1'b0, 2'b10, 3'b000, 32'h02, 32'h1234C3D2, 32'h0, 4'b1100, 32'hC3D2C3D2, 32'h0};
        vecs[2] = '{1'b0, 2'b11, 3'b000, 32'h04, 32'h01234567, 32'h0, 4'b1111, 32'h01234567, 32'h0};
        vecs[3] = '{1'b1, 2'b00, 3'b000, 32'h00, 32'h0, 32'h11223380, 4'b0001, 32'h0, 32'hFFFFFF80};
        vecs[4] = '{1'b1, 2'b00, 3'b100, 32'h02, 32'h0, 32'h11AA3344, 4'b0100, 32'h0, 32'h000000AA};
        vecs[5] = '{1'b1, 2'b00, 3'b001, 32'h00, 32'h0, 32'h1234F00F, 4'b0011, 32'h0, 32'hFFFFF00F};
        vecs[6] = '{1'b1, 2'b00, 3'b001, 32'h02, 32'h0, 32'h7FFF0000, 4'b1100, 32'h0, 32'h00007FFF};
        vecs[7] = '{1'b1, 2'b00, 3'b101, 32'h00, 32'h0, 32'hAAAA8001, 4'b0011, 32'h0, 32'h00008001};
        vecs[8] = '{1'b1, 2'b00, 3'b010, 32'h08, 32'h0, 32'hCAFEF00D, 4'b1111, 32'h0, 32'hCAFEF00D};
        vecs[9] = '{1'b1, 2'b00, 3'b100, 32'h03, 32'h0, 32'hFE000000, 4'b1000, 32'h0, 32'h000000FE};
        lsz_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        // Reset: an op on E and a clock edge under reset leave everything at zero.
        rst_n = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        set_e(1'b1, 2'b01, 2'b00, 3'b010, 5'd3, 32'h40, 32'h0, 32'h44);
        #12;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(StallM), 32'd0);
        chk("rst_mis", 32'(misaligned_err), 32'd0);
        chk("rst_rw_w", 32'(RegWriteW), 32'd0);
        chk("rst_rd_w", 32'(RdW), 32'd0);
        chk("rst_pc4_w", PCPlus4W, 32'd0);
        chk("rst_alu_m", ALUResultM, 32'd0);
        nop_e();
        rst_n = 1'b1;
        tick();

        // sw 0x100, granted in the request cycle
        issue(1'b0, 2'b00, 2'b11, 3'b000, 5'd0, 32'h100, 32'hDEADBEEF, 32'h10);
        dmem_gnt = 1'b1;
        #4;
        chk("sw_req", 32'(dmem_req), 32'd1);
        chk("sw_we", 32'(dmem_we), 32'd1);
        chk("sw_addr", dmem_addr, 32'h100);
        chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
        chk("sw_be", 32'(dmem_be), 32'hF);
        chk("sw_stall", 32'(StallM), 32'd0);
        tick();
        dmem_gnt = 1'b0;
        chk("sw_rw_w", 32'(RegWriteW), 32'd0);
        #4;
        chk("sw_req_after", 32'(dmem_req), 32'd0);
        chk("sw_stall_after", 32'(StallM), 32'd0);
        tick();

        // lb 0x103: gnt in cycle 0, rvalid in cycle 1
        issue(1'b1, 2'b01, 2'b00, 3'b000, 5'd5, 32'h103, 32'h0, 32'h20);
        dmem_gnt = 1'b1;
        #4;
        chk("lb_req", 32'(dmem_req), 32'd1);
        chk("lb_we", 32'(dmem_we), 32'd0);
        chk("lb_addr", dmem_addr, 32'h100);
        chk("lb_be", 32'(dmem_be), 32'b1000);
        chk("lb_stall0", 32'(StallM), 32'd1);
        tick();
        dmem_gnt = 1'b0;
        chk("lb_bubble", 32'(RegWriteW), 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h80FFFF7F;
        #4;
        chk("lb_stall1", 32'(StallM), 32'd0);
        chk("lb_req1", 32'(dmem_req), 32'd0);
        tick();
        dmem_rvalid = 1'b0;
        chk("lb_rdata_w", ReadDataW, 32'hFFFFFF80);
        chk("lb_rw_w", 32'(RegWriteW), 32'd1);
        chk("lb_rd_w", 32'(RdW), 32'd5);

        // lhu 0x102: gnt after 3 waiting cycles (with a stray rvalid), rvalid 2 later
        issue(1'b1, 2'b01, 2'b00, 3'b101, 5'd9, 32'h102, 32'h0, 32'h30);
        stalls = 0;
        for (int c = 0; c < 6; c++) begin
            dmem_gnt    = (c == 3);
            dmem_rvalid = (c == 3) || (c == 5);
            dmem_rdata  = (c == 5) ? 32'hBEEF1234 : 32'h0000DEAD;
            #4;
            if (c <= 3) begin
                chk("lhu_req", 32'(dmem_req), 32'd1);
                chk("lhu_addr", dmem_addr, 32'h100);
                chk("lhu_be", 32'(dmem_be), 32'b1100);
            end
            if (StallM) stalls++;
            tick();
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        chk("lhu_stalls", 32'(stalls), 32'd5);
        chk("lhu_rdata_w", ReadDataW, 32'h0000BEEF);
        chk("lhu_rw_w", 32'(RegWriteW), 32'd1);
        chk("lhu_rd_w", 32'(RdW), 32'd9);

        // Misaligned sh 0x101 and lw 0x102
        issue(1'b0, 2'b00, 2'b10, 3'b000, 5'd0, 32'h101, 32'h1234, 32'h40);
        dmem_gnt = 1'b1;
        #4;
        chk("sh_mis_req", 32'(dmem_req), 32'd0);
        chk("sh_mis_err", 32'(misaligned_err), 32'd1);
        chk("sh_mis_stall", 32'(StallM), 32'd0);
        tick();
        dmem_gnt = 1'b0;
        chk("sh_mis_rw_w", 32'(RegWriteW), 32'd0);
        #4;
        chk("sh_mis_err_off", 32'(misaligned_err), 32'd0);
        tick();
        issue(1'b1, 2'b01, 2'b00, 3'b010, 5'd6, 32'h102, 32'h0, 32'h44);
        #4;
        chk("lw_mis_req", 32'(dmem_req), 32'd0);
        chk("lw_mis_err", 32'(misaligned_err), 32'd1);
        tick();
        chk("lw_mis_rw_w", 32'(RegWriteW), 32'd0);

        // Table of single-beat stores and loads
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].ld, vecs[i].ld ? 2'b01 : 2'b00, vecs[i].mw, vecs[i].ls,
                  5'(i + 1), vecs[i].addr, vecs[i].wd, 32'h0);
            dmem_gnt = 1'b1;
            #4;
            chk("tbl_req", 32'(dmem_req), 32'd1);
            chk("tbl_be", 32'(dmem_be), 32'(vecs[i].be));
            if (!vecs[i].ld) chk("tbl_wdata", dmem_wdata, vecs[i].exp_wdata);
            tick();
            dmem_gnt = 1'b0;
            if (vecs[i].ld) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = vecs[i].rdata;
                #4;
                chk("tbl_ld_stall", 32'(StallM), 32'd0);
                tick();
                dmem_rvalid = 1'b0;
                chk("tbl_rdata_w", ReadDataW, vecs[i].exp_rd);
                chk("tbl_ld_rw_w", 32'(RegWriteW), 32'd1);
            end else begin
                chk("tbl_st_rw_w", 32'(RegWriteW), 32'd0);
            end
        end

        // Reset while waiting for rvalid; late rvalid afterwards is dropped
        issue(1'b1, 2'b01, 2'b00, 3'b010, 5'd4, 32'h200, 32'h0, 32'h50);
        dmem_gnt = 1'b1;
        #4;
        tick();
        dmem_gnt = 1'b0;
        #2;
        chk("rsp_stall_pre", 32'(StallM), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(dmem_req), 32'd0);
        chk("arst_stall", 32'(StallM), 32'd0);
        chk("arst_addr", dmem_addr, 32'd0);
        chk("arst_be", 32'(dmem_be), 32'd0);
        chk("arst_alu_m", ALUResultM, 32'd0);
        chk("arst_rd_m", 32'(RdM), 32'd0);
        chk("arst_rw_w", 32'(RegWriteW), 32'd0);
        chk("arst_rdata_w", ReadDataW, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h77777777;
        #4;
        chk("late_rv_stall", 32'(StallM), 32'd0);
        chk("late_rv_req", 32'(dmem_req), 32'd0);
        tick();
        dmem_rvalid = 1'b0;
        chk("late_rv_rw_w", 32'(RegWriteW), 32'd0);

        // lw, add, sb back to back
        set_e(1'b1, 2'b01, 2'b00, 3'b010, 5'd3, 32'h300, 32'h0, 32'h60);
        tick();
        set_e(1'b1, 2'b00, 2'b00, 3'b000, 5'd7, 32'h55, 32'h0, 32'h64);
        dmem_gnt = 1'b1;
        #4;
        chk("b2b_lw_req", 32'(dmem_req), 32'd1);
        chk("b2b_lw_stall", 32'(StallM), 32'd1);
        tick();
        dmem_gnt = 1'b0;
        chk("b2b_bubble", 32'(RegWriteW), 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h12345678;
        #4;
        chk("b2b_lw_done", 32'(StallM), 32'd0);
        tick();
        dmem_rvalid = 1'b0;
        chk("b2b_lw_w", 32'(RdW), 32'd3);
        chk("b2b_lw_rdata", ReadDataW, 32'h12345678);
        chk("b2b_add_m", 32'(RdM), 32'd7);
        chk("b2b_add_rw_m", 32'(RegWriteM), 32'd1);
        set_e(1'b0, 2'b00, 2'b01, 3'b000, 5'd0, 32'h305, 32'h0000005A, 32'h68);
        #4;
        chk("b2b_add_req", 32'(dmem_req), 32'd0);
        tick();
        nop_e();
        chk("b2b_add_w", 32'(RdW), 32'd7);
        chk("b2b_add_alu_w", ALUResultW, 32'h55);
        chk("b2b_add_rw_w", 32'(RegWriteW), 32'd1);
        dmem_gnt = 1'b1;
        #4;
        chk("b2b_sb_req", 32'(dmem_req), 32'd1);
        chk("b2b_sb_addr", dmem_addr, 32'h304);
        chk("b2b_sb_be", 32'(dmem_be), 32'b0010);
        chk("b2b_sb_wdata", dmem_wdata, 32'h5A5A5A5A);
        chk("b2b_sb_stall", 32'(StallM), 32'd0);
        tick();
        dmem_gnt = 1'b0;
        chk("b2b_sb_rw_w", 32'(RegWriteW), 32'd0);

        run_random(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
